// File: rtl/ask4_pkg.sv
// ask4_pkg: shared types for the 4-ASK receive checker.
// Gray symbol encodings and alignment FSM states.
package ask4_pkg;

  typedef enum logic [1:0] {
    SYM_P3 = 2'b00,
    SYM_P1 = 2'b01,
    SYM_M1 = 2'b11,
    SYM_M3 = 2'b10
  } sym_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/ask4_symbol_checker_if.sv
// ask4_symbol_checker_if: sample/reference inputs and checker status.
// master drives samples, slave is the checker.
interface ask4_symbol_checker_if #(
  parameter int MAX_DELAY = 16,
  parameter int CNT_W     = 32
);
  localparam int DW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic               sym_clk_ena;
  logic [1:0]         ref_symbol;
  logic signed [17:0] rx_sample;
  logic signed [17:0] threshold;
  logic               clear_counts;
  logic [1:0]         decision;
  logic               decision_valid;
  logic               locked;
  logic [DW-1:0]      delay_sel;
  logic [CNT_W-1:0]   sym_count;
  logic [CNT_W-1:0]   err_count;
  logic               err_flag;

  modport master (
    output sym_clk_ena, ref_symbol, rx_sample,
    output threshold, clear_counts,
    input  decision, decision_valid, locked,
    input  delay_sel, sym_count, err_count, err_flag
  );

  modport slave (
    input  sym_clk_ena, ref_symbol, rx_sample,
    input  threshold, clear_counts,
    output decision, decision_valid, locked,
    output delay_sel, sym_count, err_count, err_flag
  );

endinterface

// File: rtl/ask4_slicer.sv
// ask4_slicer: 4-ASK Gray slicer with its decision register.
// ASK4_AUTO_THRESH_EN: T from a leaky |rx| average, threshold ignored.
module ask4_slicer
  import ask4_pkg::*;
`ifdef ASK4_AUTO_THRESH_EN
#(
  parameter int AVG_SHIFT = 8
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic signed [17:0] rx,
  input  logic signed [17:0] thr,
  output sym_t               sym
);

  logic signed [18:0] rx_w;
  logic signed [18:0] t_w;
  logic signed [18:0] t_n;
  sym_t               sym_d;

  // 19 bits so that negating -131072 and -T cannot overflow
  assign rx_w = {rx[17], rx};

`ifdef ASK4_AUTO_THRESH_EN
  logic signed [18:0] mag;
  logic signed [18:0] avg_q;
  logic [17:0]        unused_thr;

  assign unused_thr = thr;
  assign mag = rx_w[18] ? -rx_w : rx_w;
  assign t_w = avg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_q <= '0;
    end else if (ena) begin
      avg_q <= avg_q + ((mag - avg_q) >>> AVG_SHIFT);
    end
  end
`else
  assign t_w = {thr[17], thr};
`endif

  assign t_n = -t_w;

  always_comb begin
    sym_d = SYM_M3;
    unique case (1'b1)
      (rx_w >= t_w):
        sym_d = SYM_P3;
      (rx_w < t_w) && !rx_w[18]:
        sym_d = SYM_P1;
      rx_w[18] && (rx_w > t_n):
        sym_d = SYM_M1;
      rx_w[18] && (rx_w <= t_n):
        sym_d = SYM_M3;
      default:
        sym_d = SYM_M3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym <= SYM_P3;
    end else if (ena) begin
      sym <= sym_d;
    end
  end

endmodule

// File: rtl/ask4_symbol_checker.sv
// ask4_symbol_checker: aligns sliced symbols to the LFSR reference and counts errors.
// ASK4_AUTO_THRESH_EN selects the averaged decision threshold.
module ask4_symbol_checker
  import ask4_pkg::*;
#(
  parameter int MAX_DELAY    = 16,
  parameter int SYNC_LEN     = 64,
  parameter int SYNC_ERR_MAX = 2,
  parameter int LOSS_ERR_MAX = 16,
  parameter int CNT_W        = 32,
  parameter int AVG_SHIFT    = 8
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  ask4_symbol_checker_if.slave   bus
);

  localparam int DW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int WW = $clog2(SYNC_LEN + 1);

  if (AVG_SHIFT < 0 || AVG_SHIFT > 18) begin : g_bad_shift
    $error("ask4_symbol_checker: AVG_SHIFT out of range");
  end

  sym_t             dec_q;
  logic             dv_q;
  sym_t             ref_dly [MAX_DELAY];
  state_t           state_q, state_d;
  logic [DW-1:0]    dsel_q, dsel_d, dsel_inc;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [WW-1:0]    werr_q, werr_d, werr_tot;
  logic [CNT_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             eflag_q;
  logic             mis;
  logic             win_end;

  ask4_slicer
`ifdef ASK4_AUTO_THRESH_EN
  #(.AVG_SHIFT(AVG_SHIFT))
`endif
  u_slicer (
    .clk (sys_clk),
    .rst (reset),
    .ena (bus.sym_clk_ena),
    .rx  (bus.rx_sample),
    .thr (bus.threshold),
    .sym (dec_q)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dv_q <= 1'b0;
      for (int k = 0; k < MAX_DELAY; k++) begin
        ref_dly[k] <= SYM_P3;
      end
    end else begin
      dv_q <= bus.sym_clk_ena;
      if (bus.sym_clk_ena) begin
        ref_dly[0] <= sym_t'(bus.ref_symbol);
        for (int k = 1; k < MAX_DELAY; k++) begin
          ref_dly[k] <= ref_dly[k-1];
        end
      end
    end
  end

  // compare runs the cycle after each enable
  assign mis      = dv_q && (dec_q != ref_dly[dsel_q]);
  assign werr_tot = werr_q + WW'(mis);
  assign win_end  = dv_q && (wcnt_q == WW'(SYNC_LEN - 1));
  assign dsel_inc = (dsel_q == DW'(MAX_DELAY - 1)) ?
                    '0 : dsel_q + 1'b1;

  always_comb begin
    state_d = state_q;
    dsel_d  = dsel_q;
    wcnt_d  = wcnt_q;
    werr_d  = werr_q;
    sym_d   = sym_q;
    err_d   = err_q;
    if (dv_q) begin
      wcnt_d = wcnt_q + 1'b1;
      werr_d = werr_tot;
      if (state_q == LOCKED) begin
        if (sym_q != '1) sym_d = sym_q + 1'b1;
        if (mis && err_q != '1) err_d = err_q + 1'b1;
      end
    end
    // closing compare belongs to the outgoing window and state
    if (win_end) begin
      wcnt_d = '0;
      werr_d = '0;
      unique case (state_q)
        SEARCH: begin
          if (werr_tot <= WW'(SYNC_ERR_MAX)) state_d = LOCKED;
          else dsel_d = dsel_inc;
        end
        LOCKED: begin
          if (werr_tot > WW'(LOSS_ERR_MAX)) begin
            state_d = SEARCH;
            dsel_d  = dsel_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (bus.clear_counts) begin
      sym_d = '0;
      err_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      dsel_q  <= '0;
      wcnt_q  <= '0;
      werr_q  <= '0;
      sym_q   <= '0;
      err_q   <= '0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dsel_q  <= dsel_d;
      wcnt_q  <= wcnt_d;
      werr_q  <= werr_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
      eflag_q <= mis;
    end
  end

  assign bus.decision       = dec_q;
  assign bus.decision_valid = dv_q;
  assign bus.locked         = (state_q == LOCKED);
  assign bus.delay_sel      = dsel_q;
  assign bus.sym_count      = sym_q;
  assign bus.err_count      = err_q;
  assign bus.err_flag       = eflag_q;

endmodule

// File: tb/tb_ask4_symbol_checker.sv
// tb_ask4_symbol_checker: random and directed stimulus against a
// behavioural model of slicing, alignment search and error counting.
module tb_ask4_symbol_checker;

  localparam int MAXD = 16;
  localparam int SLEN = 64;
  localparam int SERR = 2;
  localparam int LERR = 16;
  localparam int CW   = 4;
  localparam int A    = 16384;
  localparam int T0   = 32768;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ask4_symbol_checker_if #(.MAX_DELAY(MAXD), .CNT_W(CW)) bus();

  ask4_symbol_checker #(
    .MAX_DELAY(MAXD), .SYNC_LEN(SLEN), .SYNC_ERR_MAX(SERR),
    .LOSS_ERR_MAX(LERR), .CNT_W(CW), .AVG_SHIFT(8)
  ) dut (
    .sys_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_dec, m_dv, m_locked, m_d, m_wn, m_we;
  int m_sym, m_err, m_eflag;
  int hist[$];
  int tx[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int slice_m(int rx, int t);
    if (rx >= t) return 0;
    if (rx >= 0) return 1;
    if (rx > -t) return 3;
    return 2;
  endfunction

  function automatic int lvl(int s);
    case (s)
      0: return 3 * A;
      1: return A;
      3: return -A;
      default: return -3 * A;
    endcase
  endfunction

  function automatic int sat(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_dec = 0; m_dv = 0; m_locked = 0; m_d = 0;
    m_wn = 0; m_we = 0; m_sym = 0; m_err = 0; m_eflag = 0;
    hist.delete();
    repeat (MAXD) hist.push_back(0);
  endtask

  task automatic model_clk(bit ena, int rs, int rx, int t, bit clr);
    int mis;
    m_eflag = 0;
    if (m_dv != 0) begin
      mis = (m_dec != hist[m_d]) ? 1 : 0;
      m_eflag = mis;
      if (m_locked != 0) begin
        m_sym = sat(m_sym);
        if (mis != 0) m_err = sat(m_err);
      end
      m_wn++;
      m_we += mis;
      if (m_wn == SLEN) begin
        if (m_locked == 0) begin
          if (m_we <= SERR) m_locked = 1;
          else m_d = (m_d + 1) % MAXD;
        end else if (m_we > LERR) begin
          m_locked = 0;
          m_d = (m_d + 1) % MAXD;
        end
        m_wn = 0;
        m_we = 0;
      end
    end
    if (clr) begin
      m_sym = 0;
      m_err = 0;
    end
    if (ena) begin
      m_dec = slice_m(rx, t);
      hist.push_front(rs);
      void'(hist.pop_back());
    end
    m_dv = ena ? 1 : 0;
  endtask

  task automatic check_all();
    chk("decision", 32'(bus.decision), m_dec);
    chk("decision_valid", 32'(bus.decision_valid), m_dv);
    chk("locked", 32'(bus.locked), m_locked);
    chk("delay_sel", 32'(bus.delay_sel), m_d);
    chk("sym_count", 32'(bus.sym_count), m_sym);
    chk("err_count", 32'(bus.err_count), m_err);
    chk("err_flag", 32'(bus.err_flag), m_eflag);
  endtask

  task automatic cyc(bit ena, int rs, int rx, int t, bit clr);
    bus.sym_clk_ena  = ena;
    bus.ref_symbol   = 2'(rs);
    bus.rx_sample    = 18'(rx);
    bus.threshold    = 18'(t);
    bus.clear_counts = clr;
    @(posedge clk);
    model_clk(ena, rs, rx, t, clr);
    #1 check_all();
    @(negedge clk);
  endtask

  // one symbol on the link: rx carries the symbol sent lag enables ago
  task automatic link(int lag, bit corrupt, bit clr);
    int r, s, rx;
    r = int'($urandom_range(0, 3));
    tx.push_front(r);
    if (tx.size() > 64) void'(tx.pop_back());
    s = (lag < tx.size()) ? tx[lag] : 0;
    if (corrupt) s = s ^ 1;
    rx = lvl(s) + int'($urandom_range(0, 8192)) - 4096;
    cyc(1'b1, r, rx, T0, 1'b0);
    cyc(1'b0, r, rx, T0, clr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tx.delete();
  endtask

  int d_rx[13]  = '{3*A, A, -A, -3*A, 0, -T0, T0, T0-1,
                    -T0+1, -131072, 0, -1, 131071};
  int d_t[13]   = '{T0, T0, T0, T0, T0, T0, T0, T0,
                    T0, 131071, 0, 0, 131071};
  int d_exp[13] = '{0, 1, 3, 2, 1, 2, 0, 1, 3, 2, 0, 2, 0};

  initial begin
    int n, rx, t, prev_d;
    bit ever_locked, wrapped;

    bus.sym_clk_ena  = 1'b0;
    bus.ref_symbol   = 2'b00;
    bus.rx_sample    = '0;
    bus.threshold    = 18'(T0);
    bus.clear_counts = 1'b0;
    @(negedge clk);
    do_reset();

    // slicer levels and boundaries
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, 0, d_rx[i], d_t[i], 1'b0);
      chk("slice_dir", 32'(bus.decision), d_exp[i]);
      cyc(1'b0, 0, d_rx[i], d_t[i], 1'b0);
    end

    // random samples, thresholds and enable spacing
    repeat (200) begin
      rx = int'($urandom_range(0, 262143)) - 131072;
      t  = int'($urandom_range(0, 131071));
      cyc(1'b1, int'($urandom_range(0, 3)), rx, t, 1'b0);
      repeat ($urandom_range(0, 2)) cyc(1'b0, 0, rx, t, 1'b0);
    end

    // ideal loopback, lag 5
    do_reset();
    n = 0;
    while (!bus.locked && n < 7 * SLEN) begin
      link(5, 1'b0, 1'b0);
      n++;
    end
    chk("lag5_locked", 32'(bus.locked), 1);
    chk("lag5_enables", n, 6 * SLEN);
    chk("lag5_dsel", 32'(bus.delay_sel), 5);
    chk("lag5_err", 32'(bus.err_count), 0);
    repeat (100) link(5, 1'b0, 1'b0);
    chk("lag5_err_hold", 32'(bus.err_count), 0);
    chk("lag5_sym_sat", 32'(bus.sym_count), CMAX);

    // burst of bad decisions drops lock
    n = 0;
    while (bus.locked && n < 2 * SLEN) begin
      link(5, 1'b1, 1'b0);
      n++;
    end
    chk("loss_unlocked", 32'(bus.locked), 0);
    chk("loss_dsel", 32'(bus.delay_sel), 6);
    repeat (20) link(5, 1'b0, 1'b0);

    // lag beyond the delay line: never locks, delay_sel wraps
    do_reset();
    ever_locked = 1'b0;
    wrapped = 1'b0;
    prev_d = 0;
    repeat (17 * SLEN) begin
      link(20, 1'b0, 1'b0);
      if (bus.locked) ever_locked = 1'b1;
      if (prev_d == MAXD - 1 && bus.delay_sel == 0) wrapped = 1'b1;
      prev_d = int'(bus.delay_sel);
    end
    chk("lag20_never_locked", 32'(ever_locked), 0);
    chk("lag20_wrapped", 32'(wrapped), 1);

    // saturation with one error per two symbols
    do_reset();
    n = 0;
    while (!bus.locked && n < 5 * SLEN) begin
      link(3, 1'b0, 1'b0);
      n++;
    end
    chk("lag3_locked", 32'(bus.locked), 1);
    chk("lag3_dsel", 32'(bus.delay_sel), 3);
    link(3, 1'b0, 1'b1);
    chk("clr_sym", 32'(bus.sym_count), 0);
    chk("clr_err", 32'(bus.err_count), 0);
    for (int i = 0; i < 16; i++) link(3, (i % 2) == 0, 1'b0);
    chk("sat_sym16", 32'(bus.sym_count), CMAX);
    chk("sat_err16", 32'(bus.err_count), 8);
    for (int i = 0; i < 16; i++) link(3, (i % 2) == 0, 1'b0);
    chk("sat_sym32", 32'(bus.sym_count), CMAX);
    chk("sat_err32", 32'(bus.err_count), CMAX);
    chk("sat_locked", 32'(bus.locked), 1);

    // clear coincident with a mismatch
    link(3, 1'b1, 1'b1);
    chk("clrmis_sym", 32'(bus.sym_count), 0);
    chk("clrmis_err", 32'(bus.err_count), 0);
    chk("clrmis_flag", 32'(bus.err_flag), 1);
    chk("clrmis_locked", 32'(bus.locked), 1);

    // reset in the middle of a window
    repeat (10) link(3, 1'b0, 1'b0);
    do_reset();
    chk("midrst_locked", 32'(bus.locked), 0);
    chk("midrst_dsel", 32'(bus.delay_sel), 0);
    repeat (5) link(3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
